empty_ptr_sched: RTL

//  Shares the single-port empty-pointer storage between N_REQ allocators (insert engines)
//  and N_REQ releasers (delete engines).
//  - Storage drops an add when a read-ack happens in the same cycle, so this block issues
//    at most one storage operation (alloc OR free) per cycle.
//  - Round-robin arbitration within each side; alloc and free alternate when both contend.

---
 rtl/empty_ptr_sched.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/empty_ptr_sched.sv
// Arbitrates single-port empty-pointer storage between alloc and free requesters.
// Optional statistics counters enabled by defining EPS_SCHED_STATS_EN.
module empty_ptr_sched #(
  parameter int A_WIDTH   = 8,
  parameter int N_REQ     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         alloc_req_i,
  output logic [N_REQ-1:0]         alloc_ack_o,
  output logic [A_WIDTH-1:0]       alloc_ptr_o,
  input  logic [N_REQ-1:0]         free_val_i,
  input  logic [N_REQ*A_WIDTH-1:0] free_ptr_i,
  output logic [N_REQ-1:0]         free_rdy_o,
  input  logic [A_WIDTH-1:0]       eps_ptr_i,
  input  logic                     eps_ptr_val_i,
  output logic                     eps_rd_ack_o,
  output logic [A_WIDTH-1:0]       eps_add_ptr_o,
  output logic                     eps_add_en_o,
  output logic                     no_empty_o
`ifdef EPS_SCHED_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]     alloc_cnt_o,
  output logic [CNT_WIDTH-1:0]     free_cnt_o,
  output logic [CNT_WIDTH-1:0]     stall_cnt_o
`endif
);

  localparam int RW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] a_oh;
  logic [N_REQ-1:0] f_oh;
  logic [RW-1:0]    alloc_rr;
  logic [RW-1:0]    free_rr;
  logic [RW-1:0]    a_pick;
  logic [RW-1:0]    f_pick;
  logic [RW-1:0]    a_idx;
  logic [RW-1:0]    f_idx;
  logic [RW-1:0]    a_next;
  logic [RW-1:0]    f_next;
  logic             a_any;
  logic             f_any;
  logic             alloc_cand;
  logic             free_cand;
  logic             do_alloc;
  logic             do_free;
  logic             op_pri;
  logic             stall;
  int               ai;
  int               fi;

  // A requester whose ack is showing is masked for one cycle.
  assign elig       = alloc_req_i & ~alloc_ack_o;
  assign alloc_cand = (|elig) & eps_ptr_val_i;
  assign free_cand  = |free_val_i;
  assign stall      = (|elig) & ~eps_ptr_val_i;
  assign do_alloc   = alloc_cand & (~free_cand | ~op_pri);
  assign do_free    = free_cand & (~alloc_cand | op_pri);

  always_comb begin
    a_pick = '0;
    f_pick = '0;
    a_idx  = '0;
    f_idx  = '0;
    a_any  = 1'b0;
    f_any  = 1'b0;
    ai     = 0;
    fi     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      ai = int'(alloc_rr) + i;
      fi = int'(free_rr) + i;
      if (ai >= N_REQ) ai = ai - N_REQ;
      if (fi >= N_REQ) fi = fi - N_REQ;
      a_idx = RW'(ai);
      f_idx = RW'(fi);
      if (!a_any && elig[a_idx]) begin
        a_any  = 1'b1;
        a_pick = a_idx;
      end
      if (!f_any && free_val_i[f_idx]) begin
        f_any  = 1'b1;
        f_pick = f_idx;
      end
    end
  end

  assign a_next = (a_pick == RW'(N_REQ-1)) ? '0 : a_pick + 1'b1;
  assign f_next = (f_pick == RW'(N_REQ-1)) ? '0 : f_pick + 1'b1;

  always_comb begin
    a_oh          = '0;
    f_oh          = '0;
    eps_add_ptr_o = '0;
    for (int j = 0; j < N_REQ; j++) begin
      a_oh[j] = (a_pick == RW'(j));
      f_oh[j] = do_free && (f_pick == RW'(j));
      if (f_oh[j]) eps_add_ptr_o = free_ptr_i[j*A_WIDTH +: A_WIDTH];
    end
  end

  assign free_rdy_o   = f_oh;
  assign eps_add_en_o = do_free;
  assign eps_rd_ack_o = do_alloc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alloc_ack_o <= '0;
      alloc_ptr_o <= '0;
      no_empty_o  <= 1'b0;
      op_pri      <= 1'b0;
      alloc_rr    <= '0;
      free_rr     <= '0;
    end else begin
      alloc_ack_o <= do_alloc ? a_oh : '0;
      no_empty_o  <= stall;
      if (do_alloc) begin
        alloc_ptr_o <= eps_ptr_i;
        alloc_rr    <= a_next;
      end
      if (do_free) free_rr <= f_next;
      if (alloc_cand && free_cand) op_pri <= ~op_pri;
    end
  end

`ifdef EPS_SCHED_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alloc_cnt_o <= '0;
      free_cnt_o  <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (do_alloc && !(&alloc_cnt_o)) alloc_cnt_o <= alloc_cnt_o + 1'b1;
      if (do_free && !(&free_cnt_o))   free_cnt_o  <= free_cnt_o + 1'b1;
      if (stall && !(&stall_cnt_o))    stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end
`endif

endmodule
